// File: rtl/tw_rom_pkg.sv
// Shared types, sizes and constant tables for the radix-16 NTT twiddle buffer.
// The INIT table is the power-on / reset content of the reloadable table.
package tw_rom_pkg;

    localparam int unsigned P_WIDTH  = 128;
    localparam int unsigned SEG      = P_WIDTH / 2;
    localparam int unsigned STAGES   = 3;
    localparam int unsigned SC_WIDTH = 3;
    localparam int unsigned ENTRIES  = 4;
    localparam int unsigned GROUPS   = 4;
    localparam int unsigned SWEEPS   = 16;

    localparam int unsigned ST_W  = $clog2(STAGES);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned GRP_W = $clog2(GROUPS);
    localparam int unsigned SWP_W = $clog2(SWEEPS);
    localparam int unsigned PTR_W = $clog2(GROUPS * ENTRIES);

    localparam logic [STAGES-1:0] GRP_MASK = 3'b010;

    typedef logic [P_WIDTH-1:0] word_t;
    typedef logic [STAGES-1:0][GROUPS-1:0][ENTRIES-1:0][P_WIDTH-1:0] tbl_t;
    typedef logic [STAGES-1:0][P_WIDTH-1:0] const_t;

    typedef enum logic {
        EXP_HI = 1'b0,
        EXP_LO = 1'b1
    } ld_state_t;

    localparam logic [63:0] GOLDILOCKS = 64'hFFFF_FFFF_0000_0001;
    localparam word_t       ONE        = 128'h1_0000000000000001;

    // Each INIT entry carries a unique tag (stage*16 + group*4 + entry) in both halves.
    function automatic word_t init_word(input int unsigned s, input int unsigned g,
                                        input int unsigned e);
        logic [7:0] tag;
        tag = 8'(s * 16 + g * 4 + e);
        return {8'hA5, tag, 48'h0000_1111_2222, 8'h5A, tag, 48'h3333_4444_5555};
    endfunction

    function automatic tbl_t build_init();
        tbl_t t;
        t = '0;
        for (int unsigned s = 0; s < STAGES; s++)
            for (int unsigned g = 0; g < GROUPS; g++)
                for (int unsigned e = 0; e < ENTRIES; e++)
                    t[s][g][e] = init_word(s, g, e);
        return t;
    endfunction

    localparam tbl_t INIT = build_init();

    localparam const_t CONST = {
        128'h0000000000000001_fffffffeffffffc1,
        128'hfffffffeffffffc1_0200000000000000,
        128'hfffffffeffffffc1_0200000000000000
    };

endpackage

// File: rtl/tw_rd_seq.sv
// Read-address sequencer: idx/sweep/grp counters with stage-change detect.
// idx_c/grp_c is the address used by the current cycle's read.
module tw_rd_seq
    import tw_rom_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [SC_WIDTH-1:0] stage_sel,
    input  logic                rd_en,
    input  logic                rd_clr,
    output logic [IDX_W-1:0]    idx_c,
    output logic [GRP_W-1:0]    grp_c,
    output logic                stage_ok_c
);

    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SWP_W-1:0]    sweep_q, sweep_d, sweep_c;
    logic [GRP_W-1:0]    grp_q, grp_d;
    logic [SC_WIDTH-1:0] stage_q;
    logic                zero_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            sweep_q <= '0;
            grp_q   <= '0;
            stage_q <= '0;
        end else begin
            idx_q   <= idx_d;
            sweep_q <= sweep_d;
            grp_q   <= grp_d;
            if (rd_en)
                stage_q <= stage_sel;
        end
    end

    // A clear source forces address 0 for this read; a plain stage change still advances.
    always_comb begin
        stage_ok_c = (stage_sel < SC_WIDTH'(STAGES));
        zero_c     = rd_clr | (stage_sel != stage_q) | ~stage_ok_c;
        idx_c      = zero_c ? '0 : idx_q;
        sweep_c    = zero_c ? '0 : sweep_q;
        grp_c      = zero_c ? '0 : grp_q;
        idx_d      = idx_q;
        sweep_d    = sweep_q;
        grp_d      = grp_q;
        if (rd_clr || (rd_en && !stage_ok_c)) begin
            idx_d   = '0;
            sweep_d = '0;
            grp_d   = '0;
        end else if (rd_en) begin
            idx_d   = idx_c + 1'b1;
            sweep_d = sweep_c;
            grp_d   = grp_c;
            if (idx_c == IDX_W'(ENTRIES - 1)) begin
                idx_d = '0;
                if (sweep_c == SWP_W'(SWEEPS - 1)) begin
                    sweep_d = '0;
                    grp_d   = GRP_MASK[ST_W'(stage_sel)] ? GRP_W'(grp_c + 1'b1) : '0;
                end else begin
                    sweep_d = sweep_c + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tw_rom_param.sv
// Twiddle-factor buffer: STAGES x GROUPS x ENTRIES table, sequenced reads, per-stage constant.
// TW_ROM_LOAD_EN enables the run-time half-word load port; otherwise the table is the INIT ROM.
module tw_rom_param
    import tw_rom_pkg::*;
(
    input  logic                CLK,
    input  logic                rst,
    input  logic [SC_WIDTH-1:0] stage_sel,
    input  logic                rd_en,
    input  logic                rd_clr,
    input  logic                ld_start,
    input  logic [SC_WIDTH-1:0] ld_stage,
    input  logic                ld_valid,
    input  logic                ld_half,
    input  logic [SEG-1:0]      ld_data,
    output logic                ld_ready,
    output logic                ld_err,
    output logic [P_WIDTH-1:0]  Q,
    output logic                Q_valid,
    output logic [P_WIDTH-1:0]  Q_const
);

    logic [IDX_W-1:0] rd_idx_c;
    logic [GRP_W-1:0] rd_grp_c;
    logic [ST_W-1:0]  rd_stage_c;
    logic             stage_ok_c;
    word_t            rd_word_c;

    assign rd_stage_c = ST_W'(stage_sel);

    tw_rd_seq u_seq (
        .clk        (CLK),
        .rst        (rst),
        .stage_sel  (stage_sel),
        .rd_en      (rd_en),
        .rd_clr     (rd_clr),
        .idx_c      (rd_idx_c),
        .grp_c      (rd_grp_c),
        .stage_ok_c (stage_ok_c)
    );

`ifdef TW_ROM_LOAD_EN
    tbl_t                tbl;
    ld_state_t           ld_st_q, ld_st_d, cur_st;
    logic [PTR_W-1:0]    ptr_q, ptr_d, cur_ptr;
    logic [SC_WIDTH-1:0] ld_stage_q, ld_stage_d, cur_stage;
    logic                wr_hi_c, wr_lo_c, err_d;

    assign ld_ready = ld_valid;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            ld_st_q    <= EXP_HI;
            ptr_q      <= '0;
            ld_stage_q <= '0;
            ld_err     <= 1'b0;
        end else begin
            ld_st_q    <= ld_st_d;
            ptr_q      <= ptr_d;
            ld_stage_q <= ld_stage_d;
            ld_err     <= err_d;
        end
    end

    // ld_start re-arms the burst before any half arriving in the same cycle is judged.
    always_comb begin
        cur_st     = ld_st_q;
        cur_ptr    = ptr_q;
        cur_stage  = ld_stage_q;
        wr_hi_c    = 1'b0;
        wr_lo_c    = 1'b0;
        err_d      = 1'b0;
        if (ld_start) begin
            cur_st    = EXP_HI;
            cur_ptr   = '0;
            cur_stage = ld_stage;
        end
        ld_st_d    = cur_st;
        ptr_d      = cur_ptr;
        ld_stage_d = cur_stage;
        if (ld_valid) begin
            if (cur_st == EXP_HI && !ld_half) begin
                wr_hi_c = (cur_stage < SC_WIDTH'(STAGES));
                ld_st_d = EXP_LO;
            end else if (cur_st == EXP_LO && ld_half) begin
                wr_lo_c = (cur_stage < SC_WIDTH'(STAGES));
                ld_st_d = EXP_HI;
                ptr_d   = cur_ptr + 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            tbl <= INIT;
        end else begin
            if (wr_hi_c)
                tbl[ST_W'(cur_stage)][cur_ptr[PTR_W-1:IDX_W]][cur_ptr[IDX_W-1:0]][P_WIDTH-1:SEG] <= ld_data;
            if (wr_lo_c)
                tbl[ST_W'(cur_stage)][cur_ptr[PTR_W-1:IDX_W]][cur_ptr[IDX_W-1:0]][SEG-1:0] <= ld_data;
        end
    end

    assign rd_word_c = tbl[rd_stage_c][rd_grp_c][rd_idx_c];
`else
    logic unused_load;

    assign ld_ready    = 1'b0;
    assign ld_err      = 1'b0;
    assign rd_word_c   = INIT[rd_stage_c][rd_grp_c][rd_idx_c];
    assign unused_load = ^{ld_start, ld_stage, ld_valid, ld_half, ld_data};
`endif

    // Output stage: idle or invalid-stage cycles present ONE with Q_valid low.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            Q       <= ONE;
            Q_valid <= 1'b0;
            Q_const <= '0;
        end else if (rd_en && stage_ok_c) begin
            Q       <= rd_word_c;
            Q_valid <= 1'b1;
            Q_const <= CONST[rd_stage_c];
        end else begin
            Q       <= ONE;
            Q_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tw_rom_param.sv
// Scoreboard bench for tw_rom_param; load-port scenarios follow TW_ROM_LOAD_EN.
module tb_tw_rom_param;
    import tw_rom_pkg::*;

    typedef struct {
        word_t q;
        logic  v;
    } exp_t;

    logic                CLK = 1'b0;
    logic                rst;
    logic [SC_WIDTH-1:0] stage_sel;
    logic                rd_en, rd_clr, ld_start, ld_valid, ld_half;
    logic [SC_WIDTH-1:0] ld_stage;
    logic [SEG-1:0]      ld_data;
    logic                ld_ready, ld_err, Q_valid;
    logic [P_WIDTH-1:0]  Q, Q_const;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [63:0] HA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] LA = 64'h5555_5555_5555_5555;
    localparam logic [63:0] HC = 64'hCCCC_CCCC_CCCC_CCCC;

    always #5 CLK = ~CLK;

    tw_rom_param dut (
        .CLK(CLK), .rst(rst), .stage_sel(stage_sel), .rd_en(rd_en), .rd_clr(rd_clr),
        .ld_start(ld_start), .ld_stage(ld_stage), .ld_valid(ld_valid), .ld_half(ld_half),
        .ld_data(ld_data), .ld_ready(ld_ready), .ld_err(ld_err), .Q(Q), .Q_valid(Q_valid),
        .Q_const(Q_const)
    );

    function automatic exp_t rd(input int s, input int g, input int i);
        exp_t x;
        x.q = INIT[s][g][i];
        x.v = 1'b1;
        return x;
    endfunction

    function automatic exp_t idle();
        exp_t x;
        x.q = ONE;
        x.v = 1'b0;
        return x;
    endfunction

    // One clock: inputs change on the falling edge, outputs sampled 1 after the rising edge.
    task automatic step(input logic [SC_WIDTH-1:0] st, input logic en, input logic clr);
        @(negedge CLK);
        stage_sel = st;
        rd_en     = en;
        rd_clr    = clr;
        @(posedge CLK);
        #1;
        rd_clr    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stage_sel = '0; rd_en = 0; rd_clr = 0;
        ld_start = 0; ld_stage = '0; ld_valid = 0; ld_half = 0; ld_data = '0;
        repeat (3) @(posedge CLK);
        #1;
        n_tests++;
        if (Q !== ONE || Q_valid !== 1'b0 || Q_const !== '0 || ld_err !== 1'b0 || ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset Q=%h v=%b const=%h err=%b rdy=%b, expected Q=%h v=0 const=0 err=0 rdy=0",
                     Q, Q_valid, Q_const, ld_err, ld_ready, ONE);
        end
        @(negedge CLK);
        rst = 1'b0;
    endtask

    task automatic test_stage0();
        for (int n = 0; n < 5; n++) begin
            sb.push_back(rd(0, 0, n % 4));
            step(3'd0, 1'b1, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (Q !== e.q || Q_valid !== e.v) begin
                n_fail++;
                $display("FAIL stage0 n=%0d Q=%h v=%b, expected %h v=%b", n, Q, Q_valid, e.q, e.v);
            end
        end
        n_tests++;
        if (Q_const !== CONST[0]) begin
            n_fail++;
            $display("FAIL const0 Q_const=%h, expected %h", Q_const, CONST[0]);
        end
    endtask

    task automatic test_group_rotation();
        for (int n = 0; n < 257; n++) begin
            sb.push_back(rd(1, (n / 64) % 4, n % 4));
            step(3'd1, 1'b1, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (Q !== e.q || Q_valid !== e.v) begin
                n_fail++;
                $display("FAIL rotate n=%0d Q=%h v=%b, expected %h v=%b", n, Q, Q_valid, e.q, e.v);
            end
        end
        n_tests++;
        if (Q_const !== CONST[1]) begin
            n_fail++;
            $display("FAIL const1 Q_const=%h, expected %h", Q_const, CONST[1]);
        end
    endtask

    task automatic test_no_rotation();
        for (int n = 0; n < 300; n++) begin
            sb.push_back(rd(2, 0, n % 4));
            step(3'd2, 1'b1, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (Q !== e.q || Q_valid !== e.v) begin
                n_fail++;
                $display("FAIL norotate n=%0d Q=%h v=%b, expected %h v=%b", n, Q, Q_valid, e.q, e.v);
            end
        end
        sb.push_back(idle());
        step(3'd2, 1'b0, 1'b0);
        e = sb.pop_front();
        n_tests++;
        if (Q !== e.q || Q_valid !== e.v || Q_const !== CONST[2]) begin
            n_fail++;
            $display("FAIL idle Q=%h v=%b const=%h, expected %h v=0 const=%h", Q, Q_valid, Q_const, e.q, CONST[2]);
        end
    endtask

    task automatic test_clear_and_switch();
        logic [SC_WIDTH-1:0] st[$];
        logic                en[$];
        logic                cl[$];
        // stage2: idx0, idx1, clear (idle), idx0; then stage0 idx0, idx1; switch to stage1 -> entry 0
        st = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd1};
        en = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        cl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        sb.push_back(rd(2, 0, 0));
        sb.push_back(rd(2, 0, 1));
        sb.push_back(idle());
        sb.push_back(rd(2, 0, 0));
        sb.push_back(rd(0, 0, 0));
        sb.push_back(rd(0, 0, 1));
        sb.push_back(rd(1, 0, 0));
        for (int k = 0; k < 7; k++) begin
            step(st[k], en[k], cl[k]);
            e = sb.pop_front();
            n_tests++;
            if (Q !== e.q || Q_valid !== e.v) begin
                n_fail++;
                $display("FAIL clr_switch k=%0d Q=%h v=%b, expected %h v=%b", k, Q, Q_valid, e.q, e.v);
            end
        end
    endtask

    task automatic test_invalid_stage();
        sb.push_back(idle());
        step(3'd3, 1'b1, 1'b0);
        e = sb.pop_front();
        n_tests++;
        if (Q !== e.q || Q_valid !== e.v || Q_const !== CONST[1]) begin
            n_fail++;
            $display("FAIL invalid Q=%h v=%b const=%h, expected %h v=0 const=%h", Q, Q_valid, Q_const, e.q, CONST[1]);
        end
        sb.push_back(rd(1, 0, 0));
        sb.push_back(rd(1, 0, 1));
        for (int k = 0; k < 2; k++) begin
            step(3'd1, 1'b1, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (Q !== e.q || Q_valid !== e.v) begin
                n_fail++;
                $display("FAIL after_invalid k=%0d Q=%h v=%b, expected %h v=%b", k, Q, Q_valid, e.q, e.v);
            end
        end
    endtask

    task automatic load_half(input logic start, input logic half, input logic [63:0] d);
        @(negedge CLK);
        ld_start = start; ld_stage = 3'd0; ld_valid = 1'b1; ld_half = half; ld_data = d;
        #1;
        n_tests++;
`ifdef TW_ROM_LOAD_EN
        if (ld_ready !== 1'b1) begin
`else
        if (ld_ready !== 1'b0) begin
`endif
            n_fail++;
            $display("FAIL ld_ready=%b while ld_valid=1", ld_ready);
        end
        @(posedge CLK);
        #1;
        ld_start = 1'b0; ld_valid = 1'b0;
    endtask

`ifdef TW_ROM_LOAD_EN
    task automatic test_load();
        exp_t x;
        load_half(1'b1, 1'b0, HA);
        load_half(1'b0, 1'b1, LA);
        n_tests++;
        if (ld_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_err_good ld_err=%b, expected 0", ld_err);
        end
        load_half(1'b0, 1'b1, HC);
        n_tests++;
        if (ld_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ld_err_bad ld_err=%b, expected 1", ld_err);
        end
        step(3'd0, 1'b0, 1'b1);
        n_tests++;
        if (ld_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_err_pulse ld_err=%b, expected 0", ld_err);
        end
        x.q = {HA, LA}; x.v = 1'b1;
        sb.push_back(x);
        step(3'd0, 1'b1, 1'b0);
        e = sb.pop_front();
        n_tests++;
        if (Q !== e.q || Q_valid !== e.v) begin
            n_fail++;
            $display("FAIL load_rd0 Q=%h v=%b, expected %h v=%b", Q, Q_valid, e.q, e.v);
        end
        // read idx1 while its hi half is being written: old data must come back
        sb.push_back(rd(0, 0, 1));
        @(negedge CLK);
        stage_sel = 3'd0; rd_en = 1'b1; ld_valid = 1'b1; ld_half = 1'b0; ld_data = HC;
        @(posedge CLK);
        #1;
        ld_valid = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (Q !== e.q || Q_valid !== e.v) begin
            n_fail++;
            $display("FAIL collision Q=%h v=%b, expected %h v=%b", Q, Q_valid, e.q, e.v);
        end
        step(3'd0, 1'b0, 1'b1);
        x.q = {HC, INIT[0][0][1][SEG-1:0]};
        sb.push_back(rd(0, 0, 0));
        sb.push_back(x);
        sb[0].q = {HA, LA};
        for (int k = 0; k < 2; k++) begin
            step(3'd0, 1'b1, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (Q !== e.q || Q_valid !== e.v) begin
                n_fail++;
                $display("FAIL after_write k=%0d Q=%h v=%b, expected %h v=%b", k, Q, Q_valid, e.q, e.v);
            end
        end
        @(negedge CLK);
        rst = 1'b1; rd_en = 1'b0;
        @(negedge CLK);
        rst = 1'b0;
        sb.push_back(rd(0, 0, 0));
        sb.push_back(rd(0, 0, 1));
        for (int k = 0; k < 2; k++) begin
            step(3'd0, 1'b1, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (Q !== e.q || Q_valid !== e.v) begin
                n_fail++;
                $display("FAIL reset_revert k=%0d Q=%h v=%b, expected %h v=%b", k, Q, Q_valid, e.q, e.v);
            end
        end
    endtask
`else
    task automatic test_load();
        load_half(1'b1, 1'b0, HA);
        load_half(1'b0, 1'b1, LA);
        load_half(1'b0, 1'b1, HC);
        n_tests++;
        if (ld_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rom_ld_err ld_err=%b, expected 0", ld_err);
        end
        step(3'd0, 1'b0, 1'b1);
        sb.push_back(rd(0, 0, 0));
        sb.push_back(rd(0, 0, 1));
        for (int k = 0; k < 2; k++) begin
            step(3'd0, 1'b1, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (Q !== e.q || Q_valid !== e.v) begin
                n_fail++;
                $display("FAIL rom_unchanged k=%0d Q=%h v=%b, expected %h v=%b", k, Q, Q_valid, e.q, e.v);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stage0();
        test_group_rotation();
        test_no_rotation();
        test_clear_and_switch();
        test_invalid_stage();
        test_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
